// File: rtl/frame_data_reg_bank.sv
// Double-buffered per-row frame data registers: rows load into shadow storage and
// move to the active outputs together on an accepted Commit, with error and readback status.
module frame_data_reg_bank #(
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 14,
    parameter int RowSelectWidth  = 5,
    parameter bit AllowPartial    = 1'b0
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic [FrameBitsPerRow-1:0]          FrameData_I,
    input  logic [RowSelectWidth-1:0]           RowSelect,
    input  logic                                WriteEn,
    input  logic                                Commit,
    input  logic                                ClearErr,
    input  logic [RowSelectWidth-1:0]           ReadRow,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData_O,
    output logic [FrameBitsPerRow-1:0]          ReadData,
    output logic [NumRows-1:0]                  Pending,
    output logic                                CommitDone,
    output logic [2:0]                          ErrStatus
);

    typedef enum logic {IDLE, LOADING} state_e;

    logic [FrameBitsPerRow-1:0] shadow_q [NumRows];
    logic [FrameBitsPerRow-1:0] shadow_d [NumRows];
    logic [FrameBitsPerRow-1:0] active_q [NumRows];
    logic [FrameBitsPerRow-1:0] active_d [NumRows];
    logic [NumRows-1:0]         pending_q, pending_d;
    logic [FrameBitsPerRow-1:0] read_q, read_d;
    logic                       done_q, done_d;
    logic [2:0]                 err_q, err_d;

    state_e             state;
    logic [NumRows-1:0] wr_onehot;
    logic               wr_overwrite;
    logic               wr_oor;
    logic               commit_hit;
    logic               commit_accept;
    logic               commit_reject;

    // The load state is fully implied by the pending mask, so it is not stored separately.
    assign state = (pending_q != '0) ? LOADING : IDLE;

    always_comb begin
        wr_onehot = '0;
        for (int r = 0; r < NumRows; r++) begin
            if (RowSelect == RowSelectWidth'(r + 1)) begin
                wr_onehot[r] = WriteEn;
            end
        end
        wr_overwrite  = |(wr_onehot & pending_q);
        wr_oor        = WriteEn && (RowSelect > RowSelectWidth'(NumRows));
        commit_hit    = Commit && (state == LOADING);
        commit_accept = commit_hit && (AllowPartial || (&pending_q));
        commit_reject = commit_hit && !commit_accept;
    end

    // Commit samples pre-edge shadow/pending, so a same-cycle write stays pending for the next one.
    always_comb begin
        pending_d = (commit_accept ? '0 : pending_q) | wr_onehot;
        read_d    = '0;
        for (int r = 0; r < NumRows; r++) begin
            shadow_d[r] = wr_onehot[r] ? FrameData_I : shadow_q[r];
            active_d[r] = (commit_accept && pending_q[r]) ? shadow_q[r] : active_q[r];
            if (ReadRow == RowSelectWidth'(r + 1)) begin
                read_d = active_q[r];
            end
        end
        err_d  = (ClearErr ? 3'b000 : err_q) | {commit_reject, wr_overwrite, wr_oor};
        done_d = commit_accept;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NumRows; r++) begin
                shadow_q[r] <= '0;
                active_q[r] <= '0;
            end
            pending_q <= '0;
            read_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 3'b000;
        end else begin
            for (int r = 0; r < NumRows; r++) begin
                shadow_q[r] <= shadow_d[r];
                active_q[r] <= active_d[r];
            end
            pending_q <= pending_d;
            read_q    <= read_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        FrameData_O = '0;
        for (int r = 0; r < NumRows; r++) begin
            FrameData_O[r*FrameBitsPerRow +: FrameBitsPerRow] = active_q[r];
        end
    end

    assign ReadData   = read_q;
    assign Pending    = pending_q;
    assign CommitDone = done_q;
    assign ErrStatus  = err_q;

endmodule
